// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN inference core.
//   - 3-bit layer-state codes (also decoded by the weight ROM controller)
//   - default per-layer read-beat counts
//   - weight ROM base offsets of each layer after CONV1
//   - small helpers for layer ordering
package bnn_pkg;

   typedef enum logic [2:0] {
      IDLE_ST  = 3'b000,
      READ_ST  = 3'b001,
      CONV1_ST = 3'b010,
      CONV2_ST = 3'b011,
      CONV3_ST = 3'b100,
      FCL1_ST  = 3'b101,
      FCL2_ST  = 3'b110
   } layer_state_t;

   localparam int unsigned CONV1_BEATS_DEF  = 1008;  // 9 taps x 112
   localparam int unsigned CONV23_BEATS_DEF = 1008;
   localparam int unsigned FCL1_BEATS_DEF   = 672;
   localparam int unsigned FCL2_BEATS_DEF   = 12;

   // CONV1 weights occupy ROM words 0..8; later layers follow back to back.
   localparam int unsigned CONV2_ROM_OFS = 9;
   localparam int unsigned CONV3_ROM_OFS = 1017;
   localparam int unsigned FCL1_ROM_OFS  = 2025;
   localparam int unsigned FCL2_ROM_OFS  = 2697;

   function automatic layer_state_t next_layer(input layer_state_t s);
      case (s)
         CONV1_ST: return CONV2_ST;
         CONV2_ST: return CONV3_ST;
         CONV3_ST: return FCL1_ST;
         FCL1_ST:  return FCL2_ST;
         default:  return IDLE_ST;
      endcase
   endfunction

   function automatic logic is_compute(input layer_state_t s);
      return s inside {CONV1_ST, CONV2_ST, CONV3_ST, FCL1_ST, FCL2_ST};
   endfunction

endpackage

// File: rtl/bnn_beat_counter.sv
// Loadable modulo beat counter.
//   clk, rst  : clock, synchronous active-high reset
//   en        : advance by one beat
//   clr       : force count to 0 (wins over en)
//   terminal  : last count value; a beat taken at terminal wraps to 0
//   count     : current beat index
//   last      : count == terminal
module bnn_beat_counter #(
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] terminal,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   assign last = (count == terminal);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Layer scheduler for one BNN inference: IDLE -> READ -> CONV1 -> CONV2 -> CONV3 -> FCL1 -> FCL2.
//   iCLK, iRST   : clock, synchronous active-high reset
//   iSTART       : start an inference (IDLE only)
//   iLOAD_DONE   : input frame loaded (READ only)
//   iSTALL       : back-pressure, suppresses read beats (not drain)
//   iABORT       : cancel the running inference
//   oSTATE       : 3-bit layer code
//   oRD_EN       : read beat (combinational from registered state and iSTALL)
//   oBEAT        : beat index within the layer
//   oBUSY        : not IDLE
//   oLAYER_DONE  : pulse when a compute layer retires
//   oDONE        : pulse when FCL2 retires
//   oFLUSH       : pulse after an abort
module bnn_layer_sequencer
   import bnn_pkg::*;
#(
   parameter int unsigned CNT_W        = 10,
   parameter int unsigned CONV1_BEATS  = CONV1_BEATS_DEF,
   parameter int unsigned CONV23_BEATS = CONV23_BEATS_DEF,
   parameter int unsigned FCL1_BEATS   = FCL1_BEATS_DEF,
   parameter int unsigned FCL2_BEATS   = FCL2_BEATS_DEF,
   parameter int unsigned DRAIN_CYC    = 2
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSTART,
   input  logic             iLOAD_DONE,
   input  logic             iSTALL,
   input  logic             iABORT,
   output logic [2:0]       oSTATE,
   output logic             oRD_EN,
   output logic [CNT_W-1:0] oBEAT,
   output logic             oBUSY,
   output logic             oLAYER_DONE,
   output logic             oDONE,
   output logic             oFLUSH
);

   localparam int unsigned DW = ($clog2(DRAIN_CYC + 1) < 1) ? 1 : $clog2(DRAIN_CYC + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);

   layer_state_t    state_q;
   logic            draining_q;
   logic [DW-1:0]   drain_q;
   logic            busy_q;
   logic            layer_done_q;
   logic            done_q;
   logic            flush_q;

   logic [CNT_W-1:0] terminal;
   logic             beat_last;
   logic             do_abort;
   logic             last_beat;
   logic             advance;

   assign do_abort  = iABORT && (state_q != IDLE_ST);
   assign oRD_EN    = is_compute(state_q) && !iSTALL && !draining_q;
   assign last_beat = oRD_EN && beat_last;
   // Without a drain phase the layer retires on the edge after its last beat.
   assign advance   = (DRAIN_CYC == 0) ? last_beat
                                       : (draining_q && (drain_q == DRAIN_LAST));

   always_comb begin
      terminal = CNT_W'(CONV1_BEATS - 1);
      case (state_q)
         CONV2_ST, CONV3_ST: terminal = CNT_W'(CONV23_BEATS - 1);
         FCL1_ST:            terminal = CNT_W'(FCL1_BEATS - 1);
         FCL2_ST:            terminal = CNT_W'(FCL2_BEATS - 1);
         default:            terminal = CNT_W'(CONV1_BEATS - 1);
      endcase
   end

   bnn_beat_counter #(
      .CNT_W (CNT_W)
   ) u_beat_counter (
      .clk      (iCLK),
      .rst      (iRST),
      .en       (oRD_EN),
      .clr      (do_abort),
      .terminal (terminal),
      .count    (oBEAT),
      .last     (beat_last)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q      <= IDLE_ST;
         draining_q   <= 1'b0;
         drain_q      <= '0;
         busy_q       <= 1'b0;
         layer_done_q <= 1'b0;
         done_q       <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         layer_done_q <= 1'b0;
         done_q       <= 1'b0;
         flush_q      <= 1'b0;
         if (do_abort) begin
            state_q    <= IDLE_ST;
            draining_q <= 1'b0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            flush_q    <= 1'b1;
         end else if (state_q == IDLE_ST) begin
            // A start coinciding with the oDONE pulse is dropped.
            if (iSTART && !done_q) begin
               state_q <= READ_ST;
               busy_q  <= 1'b1;
            end
         end else if (state_q == READ_ST) begin
            if (iLOAD_DONE) begin
               state_q <= CONV1_ST;
            end
         end else if (!is_compute(state_q)) begin
            state_q <= IDLE_ST;
            busy_q  <= 1'b0;
         end else if (advance) begin
            state_q      <= next_layer(state_q);
            layer_done_q <= 1'b1;
            draining_q   <= 1'b0;
            drain_q      <= '0;
            if (state_q == FCL2_ST) begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end
         end else if (draining_q) begin
            // Drain keeps counting through a stall.
            drain_q <= drain_q + 1'b1;
         end else if (last_beat) begin
            draining_q <= 1'b1;
            drain_q    <= '0;
         end
      end
   end

   assign oSTATE      = state_q;
   assign oBUSY       = busy_q;
   assign oLAYER_DONE = layer_done_q;
   assign oDONE       = done_q;
   assign oFLUSH      = flush_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
module tb_bnn_layer_sequencer;

   localparam int unsigned CNT_W = 10;
   localparam int          DRAIN = 2;

   logic             iCLK = 1'b0;
   logic             iRST, iSTART, iLOAD_DONE, iSTALL, iABORT;
   logic [2:0]       oSTATE;
   logic             oRD_EN;
   logic [CNT_W-1:0] oBEAT;
   logic             oBUSY, oLAYER_DONE, oDONE, oFLUSH;

   int checks = 0;
   int errors = 0;
   int ld_cnt = 0;
   int done_cnt = 0;
   int beat_cnt = 0;

   bnn_layer_sequencer dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iSTART      (iSTART),
      .iLOAD_DONE  (iLOAD_DONE),
      .iSTALL      (iSTALL),
      .iABORT      (iABORT),
      .oSTATE      (oSTATE),
      .oRD_EN      (oRD_EN),
      .oBEAT       (oBEAT),
      .oBUSY       (oBUSY),
      .oLAYER_DONE (oLAYER_DONE),
      .oDONE       (oDONE),
      .oFLUSH      (oFLUSH)
   );

   always #5 iCLK = ~iCLK;

   // Pulse/beat tallies, sampled mid-cycle.
   always @(negedge iCLK) begin
      if (oLAYER_DONE) ld_cnt++;
      if (oDONE) done_cnt++;
      if (oRD_EN) beat_cnt++;
   end

   typedef struct {
      int code;
      int beats;
      int next_code;
   } layer_t;

   typedef struct {
      int stall_pct;
      bit drain_stall;
      bit hold_start;
      int exp_beats;
      int exp_ld;
      int exp_done;
   } run_t;

   layer_t layers[5];
   run_t   runs[3];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance to the next sampling point: 1 unit after the rising edge.
   task automatic cyc();
      @(posedge iCLK);
      #1;
   endtask

   // From IDLE: returns sampled in the first CONV1 cycle.
   task automatic start_run(input bit hold);
      cyc(); iSTART = 1'b1; iSTALL = 1'b0; #1;
      check("start_idle", int'(oSTATE), 0);
      cyc(); iSTART = hold; iLOAD_DONE = 1'b1; #1;
      check("read_state", int'(oSTATE), 1);
      check("read_rd_en", int'(oRD_EN), 0);
      check("read_busy", int'(oBUSY), 1);
      cyc(); iLOAD_DONE = 1'b0; #1;
      check("conv1_entry", int'(oSTATE), 2);
   endtask

   task automatic walk_to(input string name, input int code, input int beat);
      bit found = 1'b0;
      for (int n = 0; n < 6000; n++) begin
         if (int'(oSTATE) == code && oRD_EN && int'(oBEAT) == beat) begin
            found = 1'b1;
            break;
         end
         cyc(); iSTALL = 1'b0; #1;
      end
      check({name, "_reached"}, int'(found), 1);
   endtask

   task automatic run_inference(input int idx, input run_t r);
      int ld0, done0, beat0;
      ld0 = ld_cnt; done0 = done_cnt; beat0 = beat_cnt;
      start_run(r.hold_start);
      for (int li = 0; li < 5; li++) begin
         int beats = 0;
         int drain = 0;
         int bad_order = 0;
         int timeout = 1;
         for (int n = 0; n < 20000; n++) begin
            if (int'(oSTATE) != layers[li].code) begin
               timeout = 0;
               break;
            end
            if (oRD_EN) begin
               if (int'(oBEAT) != beats) bad_order++;
               beats++;
            end else if (beats >= layers[li].beats) begin
               drain++;
            end
            cyc();
            if (beats >= layers[li].beats && r.drain_stall) iSTALL = 1'b1;
            else iSTALL = (int'($urandom_range(99)) < r.stall_pct);
            #1;
         end
         check($sformatf("r%0d_l%0d_timeout", idx, li), timeout, 0);
         check($sformatf("r%0d_l%0d_beats", idx, li), beats, layers[li].beats);
         check($sformatf("r%0d_l%0d_beat_order", idx, li), bad_order, 0);
         check($sformatf("r%0d_l%0d_drain", idx, li), drain, DRAIN);
         check($sformatf("r%0d_l%0d_next", idx, li), int'(oSTATE), layers[li].next_code);
         check($sformatf("r%0d_l%0d_ldone", idx, li), int'(oLAYER_DONE), 1);
         check($sformatf("r%0d_l%0d_done", idx, li), int'(oDONE),
               (layers[li].next_code == 0) ? 1 : 0);
      end
      iSTALL = 1'b0;
      cyc(); #1;
      check($sformatf("r%0d_total_beats", idx), beat_cnt - beat0, r.exp_beats);
      check($sformatf("r%0d_ldone_pulses", idx), ld_cnt - ld0, r.exp_ld);
      check($sformatf("r%0d_done_pulses", idx), done_cnt - done0, r.exp_done);
      check($sformatf("r%0d_idle_after_done", idx), int'(oSTATE), 0);
      check($sformatf("r%0d_busy_after_done", idx), int'(oBUSY), 0);
      if (r.hold_start) begin
         cyc(); #1;
         check($sformatf("r%0d_restart_read", idx), int'(oSTATE), 1);
         iSTART = 1'b0; iABORT = 1'b1;
         cyc(); iABORT = 1'b0; #1;
         check($sformatf("r%0d_abort_read_state", idx), int'(oSTATE), 0);
         check($sformatf("r%0d_abort_read_flush", idx), int'(oFLUSH), 1);
      end
   endtask

   initial begin
      int ld0, done0;
      layers[0] = '{code: 2, beats: 1008, next_code: 3};
      layers[1] = '{code: 3, beats: 1008, next_code: 4};
      layers[2] = '{code: 4, beats: 1008, next_code: 5};
      layers[3] = '{code: 5, beats: 672,  next_code: 6};
      layers[4] = '{code: 6, beats: 12,   next_code: 0};
      runs[0] = '{stall_pct: 0,  drain_stall: 1'b0, hold_start: 1'b0,
                  exp_beats: 3708, exp_ld: 5, exp_done: 1};
      runs[1] = '{stall_pct: 30, drain_stall: 1'b0, hold_start: 1'b0,
                  exp_beats: 3708, exp_ld: 5, exp_done: 1};
      runs[2] = '{stall_pct: 0,  drain_stall: 1'b1, hold_start: 1'b1,
                  exp_beats: 3708, exp_ld: 5, exp_done: 1};

      iRST = 1'b1; iSTART = 1'b0; iLOAD_DONE = 1'b0; iSTALL = 1'b0; iABORT = 1'b0;
      repeat (3) @(posedge iCLK);
      #1; iRST = 1'b0; #1;
      check("rst_state", int'(oSTATE), 0);
      check("rst_rd_en", int'(oRD_EN), 0);
      check("rst_beat", int'(oBEAT), 0);
      check("rst_busy", int'(oBUSY), 0);
      check("rst_pulses", int'({oLAYER_DONE, oDONE, oFLUSH}), 0);

      // Load-done and abort have no effect in IDLE.
      iLOAD_DONE = 1'b1; iABORT = 1'b1;
      cyc(); iLOAD_DONE = 1'b0; iABORT = 1'b0; #1;
      check("idle_ignore_state", int'(oSTATE), 0);
      check("idle_ignore_flush", int'(oFLUSH), 0);

      for (int i = 0; i < 3; i++) run_inference(i, runs[i]);

      // Reset in the middle of CONV2.
      start_run(1'b0);
      walk_to("conv2", 3, 500);
      iRST = 1'b1;
      cyc(); iRST = 1'b0; #1;
      check("mid_rst_state", int'(oSTATE), 0);
      check("mid_rst_rd_en", int'(oRD_EN), 0);
      check("mid_rst_beat", int'(oBEAT), 0);
      check("mid_rst_busy", int'(oBUSY), 0);

      // Abort at FCL1 beat 300, then a clean run.
      start_run(1'b0);
      walk_to("fcl1", 5, 300);
      ld0 = ld_cnt; done0 = done_cnt;
      iABORT = 1'b1;
      cyc(); iABORT = 1'b0; #1;
      check("abort_state", int'(oSTATE), 0);
      check("abort_flush", int'(oFLUSH), 1);
      check("abort_done", int'(oDONE), 0);
      check("abort_beat", int'(oBEAT), 0);
      check("abort_busy", int'(oBUSY), 0);
      cyc(); #1;
      check("abort_flush_1cyc", int'(oFLUSH), 0);
      check("abort_no_pulses", (ld_cnt - ld0) + (done_cnt - done0), 0);
      run_inference(3, runs[0]);

      // Abort on the FCL2 last beat wins over retirement.
      start_run(1'b0);
      walk_to("fcl2_last", 6, 11);
      ld0 = ld_cnt; done0 = done_cnt;
      iABORT = 1'b1;
      cyc(); iABORT = 1'b0; #1;
      check("last_abort_state", int'(oSTATE), 0);
      check("last_abort_flush", int'(oFLUSH), 1);
      check("last_abort_done", int'(oDONE), 0);
      check("last_abort_ldone", int'(oLAYER_DONE), 0);
      repeat (4) cyc();
      #1;
      check("last_abort_no_pulses", (ld_cnt - ld0) + (done_cnt - done0), 0);
      check("last_abort_idle", int'(oSTATE), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
